// File: rtl/alu_pkg.sv
// Shared opcode encoding and NZCV flag bit positions for the datapath ALU.
package alu_pkg;

    localparam int unsigned CTRL_W  = 3;
    localparam int unsigned FLAGS_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // OP_OR becomes MUL when the ALU_MUL_EN build option is enabled
    typedef enum logic [CTRL_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_OR  = 3'b010,
        OP_XOR = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_mod_unit.sv
// Combinational N-bit unsigned restoring remainder; a divisor of zero returns a_i.
module alu_mod_unit #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] rem_c
);

    logic [N:0] rem;

    // One shift-compare-subtract step per dividend bit, MSB first
    always_comb begin
        rem = '0;
        for (int i = N - 1; i >= 0; i--) begin
            rem = {rem[N-1:0], a_i[i]};
            if (rem >= {1'b0, b_i}) begin
                rem = rem - {1'b0, b_i};
            end
        end
    end

    assign rem_c = rem[N-1:0];

endmodule

// File: rtl/alu_unit.sv
// N-bit integer ALU with registered result and NZCV flags (one cycle latency).
// Build option ALU_MUL_EN replaces OR (ctrl=010) with a low-half unsigned multiply.
module alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    input  logic [CTRL_W-1:0]    ctrl,
    output logic [N-1:0]         res,
    output logic [FLAGS_W-1:0]   flags
);

    alu_op_e              op_c;
    logic [N-1:0]         b_eff_c;
    logic [N:0]           sum_c;
    logic                 ov_c;
    logic [N-1:0]         mod_c;
    logic [N-1:0]         res_d, res_q;
    logic [FLAGS_W-1:0]   flags_d, flags_q;
    logic                 c_d, v_d;

    assign op_c = alu_op_e'(ctrl);

    // Subtract shares the adder as a + ~b + 1, so C is the no-borrow indication
    assign b_eff_c = (op_c == OP_SUB) ? ~b : b;
    assign sum_c   = {1'b0, a} + {1'b0, b_eff_c} + (N+1)'(op_c == OP_SUB);
    assign ov_c    = (a[N-1] == b_eff_c[N-1]) && (sum_c[N-1] != a[N-1]);

    alu_mod_unit #(.N(N)) u_mod (
        .a_i   (a),
        .b_i   (b),
        .rem_c (mod_c)
    );

`ifdef ALU_MUL_EN
    logic [2*N-1:0] prod_c;
    assign prod_c = {N'(0), a} * {N'(0), b};
`endif

    always_comb begin
        res_d   = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        flags_d = '0;
        case (op_c)
            OP_ADD, OP_SUB: begin
                res_d = sum_c[N-1:0];
                c_d   = sum_c[N];
                v_d   = ov_c;
            end
`ifdef ALU_MUL_EN
            OP_OR: begin
                res_d = prod_c[N-1:0];
                c_d   = |prod_c[2*N-1:N];
            end
`else
            OP_OR:  res_d = a | b;
`endif
            OP_XOR: res_d = a ^ b;
            OP_MOD: res_d = mod_c;
            OP_AND: res_d = a & b;
            OP_SHL: res_d = {a[N-2:0], 1'b0};
            OP_SHR: res_d = {1'b0, a[N-1:1]};
            default: res_d = '0;
        endcase
        flags_d[FLAG_N] = res_d[N-1];
        flags_d[FLAG_Z] = (res_d == '0);
        flags_d[FLAG_C] = c_d;
        flags_d[FLAG_V] = v_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign res   = res_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit at N=4: directed vector table, reset/latency sequences, random vs. integer model.
module tb_alu_unit;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   ctrl;
    logic [N-1:0] res;
    logic [3:0]   flags;

    int checks;
    int failures;

    alu_unit #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .ctrl  (ctrl),
        .res   (res),
        .flags (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] nzcv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] exp_res, input logic [3:0] exp_flags);
        checks++;
        if (res !== exp_res || flags !== exp_flags) begin
            failures++;
            $display("FAIL %s: got res=%b flags=%b, expected res=%b flags=%b",
                     name, res, flags, exp_res, exp_flags);
        end
    endtask

    task automatic apply(input logic r, input logic [2:0] op, input logic [3:0] ta, input logic [3:0] tb_v);
        rst  = r;
        ctrl = op;
        a    = ta;
        b    = tb_v;
        @(posedge clk);
        #1;
    endtask

    // Reference model from plain integer arithmetic; returns {res, N, Z, C, V}
    function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] ta, input logic [3:0] tb_v);
        int ua, ub, sa, sb, full, r;
        logic c, v;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: begin
                full = ua + ub;
                r = full % 16;
                c = (full > 15);
                v = ((sa + sb) > 7) || ((sa + sb) < -8);
            end
            3'd1: begin
                r = (ua - ub + 16) % 16;
                c = (ua >= ub);
                v = ((sa - sb) > 7) || ((sa - sb) < -8);
            end
`ifdef ALU_MUL_EN
            3'd2: begin
                full = ua * ub;
                r = full % 16;
                c = (full > 15);
            end
`else
            3'd2: r = int'(ta | tb_v);
`endif
            3'd3: r = int'(ta ^ tb_v);
            3'd4: r = (ub == 0) ? ua : ua % ub;
            3'd5: r = int'(ta & tb_v);
            3'd6: r = (ua * 2) % 16;
            default: r = ua / 2;
        endcase
        return {4'(r), (r >= 8), (r == 0), c, v};
    endfunction

    initial begin
        logic [7:0]  m;
        logic [2:0]  rop;
        logic [3:0]  ra, rb;
        checks   = 0;
        failures = 0;

        vecs.push_back('{"add_1_1",      3'b000, 4'b0001, 4'b0001, 4'b0010, 4'b0000});
        vecs.push_back('{"add_f_e",      3'b000, 4'b1111, 4'b1110, 4'b1101, 4'b1010});
        vecs.push_back('{"add_ovf",      3'b000, 4'b0111, 4'b0001, 4'b1000, 4'b1001});
        vecs.push_back('{"add_wrap",     3'b000, 4'b1111, 4'b1111, 4'b1110, 4'b1010});
        vecs.push_back('{"sub_eq",       3'b001, 4'b0001, 4'b0001, 4'b0000, 4'b0110});
        vecs.push_back('{"sub_borrow",   3'b001, 4'b0000, 4'b1110, 4'b0010, 4'b0000});
        vecs.push_back('{"sub_f_e",      3'b001, 4'b1111, 4'b1110, 4'b0001, 4'b0010});
        vecs.push_back('{"mod_13_10",    3'b100, 4'b1101, 4'b1010, 4'b0011, 4'b0000});
        vecs.push_back('{"mod_4_8",      3'b100, 4'b0100, 4'b1000, 4'b0100, 4'b0000});
        vecs.push_back('{"mod_0_12",     3'b100, 4'b0000, 4'b1100, 4'b0000, 4'b0100});
        vecs.push_back('{"mod_div0",     3'b100, 4'b0110, 4'b0000, 4'b0110, 4'b0000});
        vecs.push_back('{"mod_msb",      3'b100, 4'b1111, 4'b0100, 4'b0011, 4'b0000});
        vecs.push_back('{"and_n",        3'b101, 4'b1100, 4'b1110, 4'b1100, 4'b1000});
        vecs.push_back('{"and_z",        3'b101, 4'b0110, 4'b1001, 4'b0000, 4'b0100});
        vecs.push_back('{"shr_5",        3'b111, 4'b0101, 4'b0000, 4'b0010, 4'b0000});
        vecs.push_back('{"shr_c",        3'b111, 4'b1100, 4'b1111, 4'b0110, 4'b0000});
        vecs.push_back('{"shr_lsb_out",  3'b111, 4'b0001, 4'b0000, 4'b0000, 4'b0100});
`ifdef ALU_MUL_EN
        vecs.push_back('{"mul_5_3",      3'b010, 4'b0101, 4'b0011, 4'b1111, 4'b1000});
        vecs.push_back('{"mul_hi",       3'b010, 4'b0101, 4'b0100, 4'b0100, 4'b0010});
`else
        vecs.push_back('{"or",           3'b010, 4'b1010, 4'b0110, 4'b1110, 4'b1000});
`endif
        vecs.push_back('{"xor",          3'b011, 4'b1010, 4'b0110, 4'b1100, 4'b1000});
        vecs.push_back('{"shl_9",        3'b110, 4'b1001, 4'b0000, 4'b0010, 4'b0000});
        vecs.push_back('{"shl_msb_out",  3'b110, 4'b1000, 4'b0000, 4'b0000, 4'b0100});

        // Reset state
        apply(1'b1, 3'b000, 4'b0000, 4'b0000);
        apply(1'b1, 3'b000, 4'b0000, 4'b0000);
        check("reset_state", 4'b0000, 4'b0000);

        // Reset wins over a live operation, then result appears one edge after release
        apply(1'b1, 3'b000, 4'b0001, 4'b0001);
        check("reset_over_add", 4'b0000, 4'b0000);
        apply(1'b0, 3'b000, 4'b0001, 4'b0001);
        check("latency_add", 4'b0010, 4'b0000);

        // New inputs do not show before the next edge
        rst  = 1'b0;
        ctrl = 3'b001;
        a    = 4'b0001;
        b    = 4'b0001;
        #3;
        check("hold_before_edge", 4'b0010, 4'b0000);
        @(posedge clk);
        #1;
        check("sub_after_edge", 4'b0000, 4'b0110);

        // Mid-stream reset discards the in-flight result
        apply(1'b1, 3'b000, 4'b0111, 4'b0001);
        check("mid_reset", 4'b0000, 4'b0000);
        apply(1'b0, 3'b011, 4'b1111, 4'b0000);
        check("after_mid_reset", 4'b1111, 4'b1000);

        foreach (vecs[i]) begin
            apply(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
            check(vecs[i].name, vecs[i].res, vecs[i].nzcv);
        end

        // Back-to-back random operations against the integer model
        for (int k = 0; k < 400; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            m   = model(rop, ra, rb);
            apply(1'b0, rop, ra, rb);
            check("random", m[7:4], m[3:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Parameterised N-bit integer ALU for the processor datapath.
- Performs add, subtract, modulo, bitwise logic and 1-bit shifts, selected by a 3-bit control code.
- Produces the result plus NZCV condition flags, consumed by the register-file writeback and the branch/condition logic.
- Result and flags are registered: one cycle of latency.

Parameters:
- N, default 32, operand/result width in bits (N >= 2; the bench uses N=4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- a  in  N  operand A.
- b  in  N  operand B (ignored for shifts).
- ctrl  in  3  operation select.
- res  out  N  registered result.
- flags  out  4  registered flags: [3]=N negative, [2]=Z zero, [1]=C carry, [0]=V overflow.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: when rst=1 at a rising edge, res=0 and flags=4'b0000. Reset wins over any operation in that cycle.
- Latency: a, b and ctrl are sampled at rising edge k; res and flags reflect them after edge k. There is no handshake and a new operation can start every cycle. All computation is combinational ahead of the output registers.
- ctrl=000 ADD: res = a+b mod 2^N.
  - C = carry-out of bit N-1.
  - V = signed overflow: operands share a sign and the result sign differs.
- ctrl=001 SUB: res = a-b mod 2^N, computed as a + ~b + 1.
  - C = carry-out, i.e. 1 when no borrow (a >= b unsigned). Example: 0-14 gives C=0.
  - V = signed overflow: operand signs differ and the result sign differs from a.
- ctrl=010 OR: res = a | b.
- ctrl=011 XOR: res = a ^ b.
- ctrl=100 MOD: res = a % b, both operands unsigned.
  - b=0 gives res=a.
- ctrl=101 AND: res = a & b.
- ctrl=110 SHL: res = a << 1, with LSB filled by 0.
- ctrl=111 SHR: res = a >> 1, logical, with MSB filled by 0.
- Flag rules for every op:
  - N = res[N-1].
  - Z = (res == 0).
  - C and V are forced to 0 for every op except ADD and SUB. In particular, the bit shifted out by SHL/SHR is discarded and not placed in C.
- Boundaries:
  - Add wrap-around: 1111+1111 gives 1110, C=1, V=0.
  - Full-width unsigned MOD, including a with MSB set.
  - Mid-operation reset simply discards the in-flight result.

Optional Feature:
- Macro: ALU_MUL_EN.
- When defined, ctrl=010 computes MUL: res = low N bits of the unsigned a*b.
  - C = 1 if any upper N bits of the full product are nonzero.
  - V = 0.
  - N and Z follow the normal flag rules.
- When undefined, ctrl=010 is OR as specified above.
- All other opcodes are identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - an enum typedef alu_op_e for the eight ctrl codes;
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0 as bit indices.
- One sub-module, alu_mod_unit: combinational N-bit unsigned restoring remainder (a % b, returns a when b=0).
- Add/sub, logic, shift, flag generation and the output register stay in alu_unit.

Test Plan:
- N=4, ADD: a=0001, b=0001 -> res=0010, NZCV=0000. a=1111, b=1110 -> res=1101, N=1, C=1, Z=0, V=0. a=0111, b=0001 -> res=1000, N=1, V=1.
- SUB:
  - a=0001, b=0001 -> res=0000, Z=1, C=1.
  - a=0000, b=1110 -> res=0010, all flags 0.
  - a=1111, b=1110 -> res=0001, C=1.
- MOD:
  - a=1101, b=1010 -> 0011.
  - a=0100, b=1000 -> 0100.
  - a=0000, b=1100 -> 0000 with Z=1.
  - a=0110, b=0000 -> 0110.
  - C=V=0 in all cases.
- AND/SHR:
  - AND a=1100, b=1110 -> 1100, N=1.
  - AND a=0110, b=1001 -> 0000, Z=1.
  - SHR a=0101 -> 0010; a=1100 -> 0110, N=0, C=0.
- Reset/latency:
  - Drive ADD 0001+0001 with rst=1 -> after the edge res=0000, flags=0000.
  - Release rst -> res=0010 after the next edge only, confirming 1-cycle latency.
- OR/XOR/SHL: a=1010, b=0110 -> OR 1110 (N=1), XOR 1100; SHL a=1001 -> 0010, C=0.
  - With ALU_MUL_EN: a=0101, b=0011 -> res=1111, C=0.
